// File: rtl/sha_pad_sequencer.sv
// SHA padding sequencer: sizes one message, then streams one layout descriptor per padded block.
// Latency: request accepted in cycle T -> summary outputs and first blk_valid in T+2; blk_ready stalls the stream.
module sha_pad_sequencer #(
  parameter int BLK_LOG2  = 6,
  parameter int LEN_BYTES = 8,
  parameter int SIZE_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       abort,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [SIZE_W-1:0]          req_size,
  output logic [SIZE_W:0]            pad_total,
  output logic [SIZE_W+1-BLK_LOG2:0] pad_blocks,
  output logic [SIZE_W+2:0]          msg_bits,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [SIZE_W+1-BLK_LOG2:0] blk_index,
  output logic [BLK_LOG2:0]          blk_data_bytes,
  output logic                       blk_marker_en,
  output logic [BLK_LOG2-1:0]        blk_marker_pos,
  output logic                       blk_len_en,
  output logic                       blk_last,
  output logic                       done
);

  localparam int NW    = SIZE_W + 2 - BLK_LOG2;
  localparam int SUM_W = SIZE_W + 2;

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_e;

  state_e              state_q, state_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [NW-1:0]       idx_q, idx_d;
  logic [NW-1:0]       pad_blocks_q, pad_blocks_d;
  logic [SIZE_W:0]     pad_total_q, pad_total_d;
  logic [SIZE_W+2:0]   msg_bits_q, msg_bits_d;
  logic                done_q, done_d;

  logic [SUM_W-1:0]    sum;
  logic [NW-1:0]       n_calc;
  logic [NW-1:0]       full_blks;
  logic [BLK_LOG2-1:0] tail;
  logic                is_last;

  always_comb begin
    // size + 1 (marker) + LEN_BYTES + (block-1) rounding term
    sum       = SUM_W'(size_q) + SUM_W'(LEN_BYTES + (1 << BLK_LOG2));
    n_calc    = NW'(sum >> BLK_LOG2);
    full_blks = NW'(size_q >> BLK_LOG2);
    tail      = size_q[BLK_LOG2-1:0];
    is_last   = (idx_q == pad_blocks_q - 1'b1);
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    idx_d        = idx_q;
    pad_blocks_d = pad_blocks_q;
    pad_total_d  = pad_total_q;
    msg_bits_d   = msg_bits_q;
    done_d       = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_d  = req_size;
            state_d = CALC;
          end
        end
        CALC: begin
          pad_blocks_d = n_calc;
          pad_total_d  = (SIZE_W+1)'({n_calc, {BLK_LOG2{1'b0}}});
          msg_bits_d   = {size_q, 3'b000};
          idx_d        = '0;
          state_d      = EMIT;
        end
        EMIT: begin
          if (blk_ready) begin
            if (is_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= '0;
      idx_q        <= '0;
      pad_blocks_q <= '0;
      pad_total_q  <= '0;
      msg_bits_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      idx_q        <= idx_d;
      pad_blocks_q <= pad_blocks_d;
      pad_total_q  <= pad_total_d;
      msg_bits_q   <= msg_bits_d;
      done_q       <= done_d;
    end
  end

  // Descriptor fields are pure functions of idx_q, so they hold while stalled.
  always_comb begin
    blk_valid      = (state_q == EMIT);
    blk_index      = '0;
    blk_data_bytes = '0;
    blk_marker_en  = 1'b0;
    blk_marker_pos = '0;
    blk_len_en     = 1'b0;
    blk_last       = 1'b0;
    if (blk_valid) begin
      blk_index = idx_q;
      if (idx_q < full_blks) begin
        blk_data_bytes = {1'b1, {BLK_LOG2{1'b0}}};
      end else if (idx_q == full_blks) begin
        blk_data_bytes = {1'b0, tail};
      end
      blk_marker_en  = (idx_q == full_blks);
      blk_marker_pos = blk_marker_en ? tail : '0;
      blk_len_en     = is_last;
      blk_last       = is_last;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign pad_total  = pad_total_q;
  assign pad_blocks = pad_blocks_q;
  assign msg_bits   = msg_bits_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sha_pad_sequencer.sv
// Bench for sha_pad_sequencer: 64-byte and 128-byte block instances checked against an arithmetic padding model.
module tb_sha_pad_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        rv [2];
  logic [31:0] rs [2];
  logic        br [2];
  logic        ab [2];

  logic rr0, bv0, me0, le0, bl0, dn0;
  logic [32:0] pt0; logic [27:0] pb0; logic [34:0] mb0; logic [27:0] bi0;
  logic [6:0] bd0; logic [5:0] mp0;
  logic rr1, bv1, me1, le1, bl1, dn1;
  logic [32:0] pt1; logic [26:0] pb1; logic [34:0] mb1; logic [26:0] bi1;
  logic [7:0] bd1; logic [6:0] mp1;

  sha_pad_sequencer #(.BLK_LOG2(6), .LEN_BYTES(8), .SIZE_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .abort(ab[0]), .req_valid(rv[0]), .req_ready(rr0),
    .req_size(rs[0]), .pad_total(pt0), .pad_blocks(pb0), .msg_bits(mb0),
    .blk_valid(bv0), .blk_ready(br[0]), .blk_index(bi0), .blk_data_bytes(bd0),
    .blk_marker_en(me0), .blk_marker_pos(mp0), .blk_len_en(le0), .blk_last(bl0), .done(dn0));

  sha_pad_sequencer #(.BLK_LOG2(7), .LEN_BYTES(16), .SIZE_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .abort(ab[1]), .req_valid(rv[1]), .req_ready(rr1),
    .req_size(rs[1]), .pad_total(pt1), .pad_blocks(pb1), .msg_bits(mb1),
    .blk_valid(bv1), .blk_ready(br[1]), .blk_index(bi1), .blk_data_bytes(bd1),
    .blk_marker_en(me1), .blk_marker_pos(mp1), .blk_len_en(le1), .blk_last(bl1), .done(dn1));

  int sel = 0;
  logic [63:0] o_rr, o_pt, o_pb, o_mb, o_bv, o_bi, o_bd, o_me, o_mp, o_le, o_bl, o_dn;

  always_comb begin
    if (sel == 0) begin
      o_rr = 64'(rr0); o_pt = 64'(pt0); o_pb = 64'(pb0); o_mb = 64'(mb0);
      o_bv = 64'(bv0); o_bi = 64'(bi0); o_bd = 64'(bd0); o_me = 64'(me0);
      o_mp = 64'(mp0); o_le = 64'(le0); o_bl = 64'(bl0); o_dn = 64'(dn0);
    end else begin
      o_rr = 64'(rr1); o_pt = 64'(pt1); o_pb = 64'(pb1); o_mb = 64'(mb1);
      o_bv = 64'(bv1); o_bi = 64'(bi1); o_bd = 64'(bd1); o_me = 64'(me1);
      o_mp = 64'(mp1); o_le = 64'(le1); o_bl = 64'(bl1); o_dn = 64'(dn1);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d): got %0d expected %0d", tag, sel, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the padding rules.
  function automatic longint unsigned blk_of(input int d);
    return d ? 128 : 64;
  endfunction

  function automatic longint unsigned n_of(input int d, input longint unsigned sz);
    longint unsigned b, l;
    b = blk_of(d);
    l = d ? 16 : 8;
    return (sz + 1 + l + b - 1) / b;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, o_rr, 1);
    chk({tag, "_blk_valid"}, o_bv, 0);
    chk({tag, "_pad_total"}, o_pt, 0);
    chk({tag, "_pad_blocks"}, o_pb, 0);
    chk({tag, "_msg_bits"}, o_mb, 0);
    chk({tag, "_desc"}, o_bi | o_bd | o_me | o_mp | o_le | o_bl, 0);
    chk({tag, "_done"}, o_dn, 0);
  endtask

  task automatic chk_desc(input int d, input longint unsigned sz, input longint unsigned i);
    longint unsigned b, n, fb, data;
    b  = blk_of(d);
    n  = n_of(d, sz);
    fb = sz / b;
    if (sz >= (i + 1) * b) data = b;
    else if (sz > i * b)   data = sz - i * b;
    else                   data = 0;
    chk("blk_valid", o_bv, 1);
    chk("blk_index", o_bi, i);
    chk("blk_data_bytes", o_bd, data);
    chk("blk_marker_en", o_me, 64'(i == fb));
    chk("blk_marker_pos", o_mp, (i == fb) ? sz % b : 0);
    chk("blk_len_en", o_le, 64'(i == n - 1));
    chk("blk_last", o_bl, 64'(i == n - 1));
    chk("req_ready_busy", o_rr, 0);
    chk("done_busy", o_dn, 0);
  endtask

  task automatic start_job(input int d, input longint unsigned sz);
    int w;
    w = 0;
    sel = d;
    #1;
    while (o_rr !== 64'd1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_idle", o_rr, 1);
    rv[d] = 1'b1;
    rs[d] = 32'(sz);
    @(negedge clk);
    rv[d] = 1'b0;
    rs[d] = $urandom;
    chk("calc_valid_low", o_bv, 0);
    chk("calc_req_ready_low", o_rr, 0);
    @(negedge clk);
    chk("pad_blocks", o_pb, n_of(d, sz));
    chk("pad_total", o_pt, n_of(d, sz) * blk_of(d));
    chk("msg_bits", o_mb, sz * 8);
  endtask

  task automatic take_block(input int d, input longint unsigned sz, input longint unsigned i,
                            input int stall);
    chk_desc(d, sz, i);
    repeat (stall) begin
      @(negedge clk);
      chk_desc(d, sz, i);
    end
    br[d] = 1'b1;
    @(negedge clk);
    br[d] = 1'b0;
  endtask

  task automatic run_job(input int d, input longint unsigned sz, input int smin, input int smax);
    longint unsigned n;
    n = n_of(d, sz);
    start_job(d, sz);
    for (longint unsigned i = 0; i < n; i++)
      take_block(d, sz, i, int'($urandom_range(smax, smin)));
    chk("done_pulse", o_dn, 1);
    chk("req_ready_after", o_rr, 1);
    chk("valid_after", o_bv, 0);
    @(negedge clk);
    chk("done_single", o_dn, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; rs[k] = '0; br[k] = 1'b0; ab[k] = 1'b0;
    end
    #12;
    sel = 0; #1; chk_reset("reset0");
    sel = 1; #1; chk_reset("reset1");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sel = 0; #1; chk_reset("post_reset0");

    // directed boundary sizes, 64-byte block
    run_job(0, 0, 0, 0);
    run_job(0, 55, 0, 0);
    run_job(0, 56, 0, 0);
    run_job(0, 64, 0, 0);
    run_job(0, 119, 0, 0);
    chk("msg_bits_119", o_mb, 952);
    run_job(0, 200, 3, 3);
    chk("pad_total_200", o_pt, 256);

    // abort together with a handshake on block 1
    start_job(0, 300);
    take_block(0, 300, 0, 0);
    chk_desc(0, 300, 1);
    ab[0] = 1'b1; br[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0; br[0] = 1'b0;
    chk("abort_valid", o_bv, 0);
    chk("abort_req_ready", o_rr, 1);
    chk("abort_done", o_dn, 0);
    chk("abort_pad_blocks", o_pb, 5);
    chk("abort_pad_total", o_pt, 320);
    chk("abort_msg_bits", o_mb, 2400);
    @(negedge clk);
    chk("abort_done_later", o_dn, 0);
    run_job(0, 10, 0, 1);

    // abort in IDLE blocks a simultaneous request
    ab[0] = 1'b1; rv[0] = 1'b1; rs[0] = 32'd5;
    @(negedge clk);
    ab[0] = 1'b0; rv[0] = 1'b0;
    chk("idle_abort_ready", o_rr, 1);
    @(negedge clk);
    chk("idle_abort_no_job", o_bv, 0);

    // asynchronous reset mid-stream
    start_job(0, 300);
    take_block(0, 300, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rst_release");
    run_job(0, 10, 0, 1);

    // maximum size: summary only, then cancel
    start_job(0, 64'hFFFF_FFFF);
    ab[0] = 1'b1; @(negedge clk); ab[0] = 1'b0;
    chk("max_abort_valid0", o_bv, 0);

    // 128-byte block instance
    run_job(1, 111, 0, 0);
    chk("pad_total_111", o_pt, 128);
    run_job(1, 112, 0, 1);
    chk("pad_total_112", o_pt, 256);
    chk("msg_bits_112", o_mb, 896);
    start_job(1, 64'hFFFF_FFFF);
    ab[1] = 1'b1; @(negedge clk); ab[1] = 1'b0;
    chk("max_abort_valid1", o_bv, 0);

    // randomized jobs on both instances
    for (int k = 0; k < 16; k++) begin
      int d;
      longint unsigned sz;
      d = int'($urandom_range(1, 0));
      case ($urandom_range(2, 0))
        0:       sz = $urandom_range(700, 0);
        1:       sz = blk_of(d) * $urandom_range(5, 1) - $urandom_range(20, 0);
        default: sz = blk_of(d) * $urandom_range(5, 0) + $urandom_range(2, 0);
      endcase
      run_job(d, sz, 0, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_pad_sequencer.md
Name: sha_pad_sequencer

Overview:
- Parametrised successor to the SHA-1 padding-length calculator.
- Accepts one message byte length per request and computes the padded total length and block count.
- Then streams one descriptor per padded block so the block assembler knows where message bytes end, where the 0x80 marker goes, and where the length field goes.
- Supports SHA-1/SHA-256 (64-byte block, 8-byte length) and SHA-384/512 (128-byte block, 16-byte length) via parameters.

Parameters:
- BLK_LOG2, 6, log2 of block size in bytes (7 for SHA-512 family).
- LEN_BYTES, 8, bytes of the trailing length field (16 for SHA-512 family).
- SIZE_W, 32, width of the message byte-length input.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous cancel of the current job
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_size  in  SIZE_W  message length in bytes
- pad_total  out  SIZE_W+1  padded length in bytes (N<<BLK_LOG2)
- pad_blocks  out  SIZE_W+2-BLK_LOG2  block count N
- msg_bits  out  SIZE_W+3  req_size*8, the value for the length field
- blk_valid  out  1  descriptor valid
- blk_ready  in  1  descriptor accepted
- blk_index  out  SIZE_W+2-BLK_LOG2  block number, 0-based
- blk_data_bytes  out  BLK_LOG2+1  message bytes in this block, 0..2^BLK_LOG2
- blk_marker_en  out  1  0x80 marker lies in this block
- blk_marker_pos  out  BLK_LOG2  byte offset of the marker
- blk_len_en  out  1  length field occupies the final LEN_BYTES of this block
- blk_last  out  1  final block of the message
- done  out  1  one-cycle pulse after the last descriptor handshake

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1.
- FSM states: IDLE -> CALC -> EMIT -> IDLE.
- IDLE: req_valid&&req_ready latches req_size and moves to CALC.
- CALC (1 cycle), at full width with no truncation:
  - N = (size + 1 + LEN_BYTES + 2^BLK_LOG2 - 1) >> BLK_LOG2
  - pad_total = N << BLK_LOG2
  - msg_bits = size << 3
  - These three outputs are registered at CALC exit and held until the next request is accepted.
  - Moves to EMIT with index i=0.
- Latency: request accepted in cycle T -> blk_valid first high in T+2, with pad_total/pad_blocks/msg_bits valid from T+2.
- EMIT: blk_valid=1. All blk_* fields stay stable while blk_valid && !blk_ready. Each handshake increments i.
- Descriptor fields for block i:
  - blk_data_bytes = min(2^BLK_LOG2, max(0, size - i*2^BLK_LOG2))
  - blk_marker_en = (i == size>>BLK_LOG2); blk_marker_pos = size mod 2^BLK_LOG2 (0 when marker_en=0)
  - blk_len_en = blk_last = (i == N-1)
- Handshake on the last block -> IDLE; done=1 in the following cycle; req_ready returns to 1 in that same cycle.
- Boundary cases:
  - size mod block = 0 with size > 0: marker at offset 0 of block size>>BLK_LOG2, which has data_bytes=0.
  - Marker block unable to hold the length field: an extra block follows with data 0, marker_en 0, len_en 1.
  - size = 0: single block, data 0, marker 0, len_en 1.
  - Maximum size (all ones): no overflow at the declared widths.
- abort (any state): go to IDLE next cycle, blk_valid=0, no done pulse, summary outputs unchanged.
- abort takes priority over a blk handshake in the same cycle.
- abort in IDLE is ignored; a request presented with abort is not accepted.
- rst_n low mid-job: immediate return to the reset state. No partial descriptor stream resumes.
- blk_ready while blk_valid=0 is ignored. req_valid outside IDLE is ignored; it is not queued.

Test Plan:
- Defaults, size 0 -> N=1, pad_total 64, msg_bits 0; one descriptor {idx0, data0, marker_en1 pos0, len_en1, last1}; done pulse.
- size 55 -> N=1, pad_total 64, descriptor {data55, marker pos55, len_en1, last1}. size 56 -> N=2, pad_total 128: {data56, marker pos56, len0}, then {data0, marker_en0, len1, last1}.
- size 64 -> N=2: {data64, marker_en0}, {data0, marker pos0, len1, last1}. size 119 -> N=2: {data64}, {data55, marker pos55, len1, last1}, msg_bits 952.
- Backpressure: size 200, blk_ready low for 3 cycles on each descriptor.
  - Fields stay stable while stalled.
  - 4 descriptors with data 64/64/64/8; marker pos 8 in idx3; len on idx3.
  - done exactly once; req_ready stays 0 until done.
- abort asserted during the 2nd descriptor of a size-300 job -> blk_valid low next cycle, no done, req_ready 1. A following size-10 job runs correctly. Repeat with rst_n pulsed low mid-stream -> all outputs return to reset values asynchronously.
- BLK_LOG2=7, LEN_BYTES=16: size 111 -> N=1, pad_total 128. size 112 -> N=2, pad_total 256, msg_bits 896, second block {data0, marker_en0, len1}.
